// File: rtl/capture_buffer_if.sv
// Control/status bundle between capture_buffer and its VIO-side controller.
interface capture_buffer_if #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  arm;
    logic                  sample_en;
    logic [DATA_W-1:0]     probe_data;
    logic [DATA_W-1:0]     trig_mask;
    logic [DATA_W-1:0]     trig_value;
    logic [DEPTH_LOG2-1:0] post_count;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic [1:0]            state;
    logic                  triggered;
    logic                  done;
    logic [DEPTH_LOG2:0]   valid_count;
    logic [DEPTH_LOG2-1:0] trig_index;

    modport master (
        output arm, sample_en, probe_data, trig_mask, trig_value, post_count, rd_addr,
        input  rd_data, state, triggered, done, valid_count, trig_index
    );

    modport slave (
        input  arm, sample_en, probe_data, trig_mask, trig_value, post_count, rd_addr,
        output rd_data, state, triggered, done, valid_count, trig_index
    );
endinterface

// File: rtl/capture_buffer.sv
// Trigger-qualified circular capture buffer with indexed read-back of the capture window.
// Optional CAPTURE_TRIG_EDGE_EN: trigger only on a false-to-true transition of the match.
module capture_buffer #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic             my_clk,
    input logic             rst,
    capture_buffer_if.slave bus
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] Full = (DEPTH_LOG2 + 1)'(Depth);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StPost  = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic                arm_q;
    ptr_t                wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] valid_count_q, valid_count_d;
    logic                triggered_q, triggered_d;
    ptr_t                trig_ptr_q, trig_ptr_d;
    ptr_t                remaining_q, remaining_d;
    ptr_t                trig_index_q, trig_index_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem [Depth];

    logic arm_edge, match, trig_hit, capturing, wr_en;
    ptr_t start_ptr, start_ptr_d, rd_idx;

    assign arm_edge  = bus.arm & ~arm_q;
    assign match     = ((bus.probe_data ^ bus.trig_value) & bus.trig_mask) == '0;
    assign capturing = bus.sample_en & ~arm_edge & ((state_q == StArmed) | (state_q == StPost));

`ifdef CAPTURE_TRIG_EDGE_EN
    logic prev_match_q;

    always_ff @(posedge my_clk or posedge rst) begin
        if (rst) begin
            prev_match_q <= 1'b0;
        end else if (arm_edge) begin
            prev_match_q <= 1'b0;
        end else if (bus.sample_en) begin
            prev_match_q <= match;
        end
    end

    assign trig_hit = match & ~prev_match_q;
`else
    assign trig_hit = match;
`endif

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        valid_count_d = valid_count_q;
        triggered_d   = triggered_q;
        trig_ptr_d    = trig_ptr_q;
        remaining_d   = remaining_q;
        trig_index_d  = trig_index_q;
        wr_en         = 1'b0;
        if (arm_edge) begin
            state_d       = StArmed;
            wr_ptr_d      = '0;
            valid_count_d = '0;
            triggered_d   = 1'b0;
            remaining_d   = bus.post_count;
            trig_index_d  = '0;
        end else if (capturing) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (valid_count_q != Full) begin
                valid_count_d = valid_count_q + (DEPTH_LOG2 + 1)'(1);
            end
            if (state_q == StArmed) begin
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    trig_ptr_d  = wr_ptr_q;
                    state_d     = (remaining_q == '0) ? StDone : StPost;
                end
            end else begin
                remaining_d = remaining_q - ptr_t'(1);
                if (remaining_q == ptr_t'(1)) begin
                    state_d = StDone;
                end
            end
        end
        // Trigger index is frozen on the edge that enters DONE, using the final pointers.
        start_ptr_d = (valid_count_d == Full) ? wr_ptr_d : '0;
        if (state_d == StDone && state_q != StDone) begin
            trig_index_d = trig_ptr_d - start_ptr_d;
        end
    end

    assign start_ptr = (valid_count_q == Full) ? wr_ptr_q : '0;
    assign rd_idx    = start_ptr + bus.rd_addr;
    assign rd_data_d = (state_q == StDone) ? mem[rd_idx] : '0;

    always_ff @(posedge my_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            arm_q         <= 1'b0;
            wr_ptr_q      <= '0;
            valid_count_q <= '0;
            triggered_q   <= 1'b0;
            trig_ptr_q    <= '0;
            remaining_q   <= '0;
            trig_index_q  <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            arm_q         <= bus.arm;
            wr_ptr_q      <= wr_ptr_d;
            valid_count_q <= valid_count_d;
            triggered_q   <= triggered_d;
            trig_ptr_q    <= trig_ptr_d;
            remaining_q   <= remaining_d;
            trig_index_q  <= trig_index_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Sample RAM is deliberately left out of reset.
    always_ff @(posedge my_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.probe_data;
        end
    end

    assign bus.state       = state_q;
    assign bus.done        = (state_q == StDone);
    assign bus.triggered   = triggered_q;
    assign bus.valid_count = valid_count_q;
    assign bus.trig_index  = trig_index_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Trigger-qualified sample capture buffer: the read-out end of the probe path. It records a probe bus into a circular RAM around a trigger event, then presents the capture window for indexed read-back.
- Sits beside a DUT such as a flip-flop under test. probe_data comes from DUT signals; arm, trig_* and rd_addr come from VIO outputs; rd_data and status go back to VIO inputs.
- sample_en qualifies samples, e.g. a rising-edge strobe of a derived half-rate clock, so the DUT can be observed at its own rate on the fast clock.

Parameters:
- DATA_W, 4: probe/sample width in bits.
- DEPTH_LOG2, 4: log2 of buffer depth. DEPTH = 2**DEPTH_LOG2 = 16.

Ports:
- my_clk  in  1  sole clock, board clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  level from VIO; its rising edge starts a capture.
- sample_en  in  1  sample qualifier; a write occurs only on cycles with sample_en=1.
- probe_data  in  DATA_W  data to capture.
- trig_mask  in  DATA_W  bits that participate in the trigger compare.
- trig_value  in  DATA_W  trigger compare value.
- post_count  in  DEPTH_LOG2  samples captured after the trigger sample; latched at arm.
- rd_addr  in  DEPTH_LOG2  read index; 0 = oldest captured sample.
- rd_data  out  DATA_W  registered read data.
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- triggered  out  1  trigger seen in the current capture.
- done  out  1  high in DONE.
- valid_count  out  DEPTH_LOG2+1  samples held, saturates at DEPTH.
- trig_index  out  DEPTH_LOG2  read index of the trigger sample; valid in DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; triggered=0; done=0; valid_count=0; trig_index=0; rd_data=0.
  - arm edge register = 0, so arm already high at reset release counts as a rising edge.
  - RAM contents are not reset.
- Arm edge: arm=1 and arm_d=0. On that clock edge:
  - state→ARMED; wr_ptr=0; valid_count=0; triggered=0.
  - post_count is latched into remaining.
  - No sample is written on the arm-edge cycle.
  - An arm edge in any state, including ARMED or POST, aborts and restarts the capture.
- Match: ((probe_data ^ trig_value) & trig_mask) == 0. trig_mask=0 matches every sample.
- ARMED, on each cycle with sample_en=1:
  - Write probe_data at wr_ptr; wr_ptr+1 mod DEPTH; valid_count+1, saturating at DEPTH.
  - If match: triggered=1 and trig_ptr=wr_ptr.
  - Then state→DONE if remaining==0, else state→POST.
- POST, on each cycle with sample_en=1:
  - Write the sample as in ARMED; remaining−1.
  - When the sample written has remaining==1, state→DONE on that edge.
  - The match is ignored in POST.
- DONE:
  - No writes; sample_en and probe_data are ignored.
  - start_ptr = wr_ptr if valid_count==DEPTH, else 0.
  - trig_index = (trig_ptr − start_ptr) mod DEPTH.
  - rd_data = RAM[(start_ptr + rd_addr) mod DEPTH], registered with 1-cycle latency.
  - rd_addr ≥ valid_count returns stale RAM data, which is not an error.
- Outside DONE, rd_data=0.
- Capture length: with the trigger at sample T (0-based since arm), total samples captured = T+1+post_count. Only the last DEPTH of them are retained.
- done is combinational from state; all other outputs are registered.

Optional Feature:
- Macro: CAPTURE_TRIG_EDGE_EN.
- Defined: trigger fires only on a qualified sample where the match is true and the match on the previous qualified sample was false.
  - The previous-match register is cleared at the arm edge, so a match on the first sample after arm does trigger.
  - The previous-match register is updated only on sample_en cycles.
- Undefined: level trigger; any matching sample in ARMED triggers. The previous-match register is not built.

Test Plan:
- Reset: assert rst mid-POST → state=00, triggered=0, done=0, valid_count=0, rd_data=0 immediately, without waiting for a clock edge.
- Basic capture:
  - Setup: sample_en=1; probe = 4-bit counter from 0; mask=F; value=A; post_count=3; pulse arm.
  - Required: DONE after sample 0xD; valid_count=14; trig_index=10; rd_addr=13 → rd_data=0xD one cycle later.
- Wrap:
  - Setup: mask=F; value=5; post_count=2; probe = 20×0x0, then 0x5, 0x1, 0x2.
  - Required: valid_count=16; trig_index=13; rd_addr=13→0x5; rd_addr=15→0x2; rd_addr=0→0x0.
- Qualifier:
  - Setup: sample_en high every other cycle; probe changes every cycle; mask=0; post_count=3.
  - Required: only qualified-cycle values stored; valid_count=4; trig_index=0.
- post_count=0 and abort:
  - post_count=0, trigger on the 6th sample → DONE on the trigger edge; valid_count=6; trig_index=5.
  - Re-arm while in POST → state=01, triggered=0, valid_count=0.
- Edge option:
  - Setup: probe held at 0xA before and after arm; mask=F; value=A.
  - Required: level build triggers on the 1st sample.
  - Required with CAPTURE_TRIG_EDGE_EN: also triggers on the 1st sample (previous-match register cleared at arm); does not re-trigger while 0xA persists; after abort/re-arm with 0xA still present, triggers again on the 1st sample.
